// File: rtl/mul_arb_pkg.sv
// ---------------------------------------------------------------------------
// mul_arb_pkg
// Shared constants and types for the mul_arbiter codebase slice.
//   A_W / B_W / P_W : operand A, operand B and product widths (3, 4, 7)
//   state_e         : controller states IDLE, CALC, RESP
//   req_id_t        : requester identifier (0 or 1)
// ---------------------------------------------------------------------------
package mul_arb_pkg;

    localparam int A_W = 3;
    localparam int B_W = 4;
    localparam int P_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/mul_arb_mult.sv
// ---------------------------------------------------------------------------
// mul_arb_mult
// Unsigned 3-bit x 4-bit combinational array multiplier.
// Ports:
//   a_i    in   A_W  multiplicand
//   b_i    in   B_W  multiplier
//   prod_o out  P_W  a_i * b_i, full width (max 7 * 15 = 105)
// ---------------------------------------------------------------------------
module mul_arb_mult
    import mul_arb_pkg::*;
(
    input  logic [A_W-1:0] a_i,
    input  logic [B_W-1:0] b_i,
    output logic [P_W-1:0] prod_o
);

    // One partial-product row per bit of A: B shifted by the bit position.
    always_comb begin
        // NOTE: assigning a default before any conditional update keeps every
        // path assigned, so no latch is inferred.
        prod_o = '0;
        for (int i = 0; i < A_W; i++) begin
            if (a_i[i]) begin
                prod_o = prod_o + (P_W'(b_i) << i);
            end
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin picker, purely combinational.
// Ports:
//   valid      in   [1:0] request lines (bit 0 = requester 0)
//   last_grant in   1     requester that won the previous handshake
//   grant      out  1     chosen requester (meaningful only when any_valid)
//   any_valid  out  1     at least one request line is asserted
// ---------------------------------------------------------------------------
module rr_arb2
    import mul_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    output req_id_t    grant,
    output logic       any_valid
);

    // A tie goes to whichever requester did not win last time; a lone
    // request always wins.
    always_comb begin
        grant = 1'b0;
        case (valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

    assign any_valid = |valid;

endmodule

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
// Shares one 3x4 array multiplier between two requesters. A round-robin
// winner is accepted in IDLE, its operands are multiplied in CALC, and the
// registered product is held on the response channel in RESP until taken.
// Optional feature: define MUL_ARB_STATS_EN to add saturating per-requester
// grant counters (parameter CNT_W, ports grant_cnt0 / grant_cnt1).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0_valid/req1_valid  in   requester has an operand pair
//   req0_ready/req1_ready  out  requester accepted this cycle
//   req0_a/req1_a          in   multiplicand A (3 bits)
//   req0_b/req1_b          in   multiplier B (4 bits)
//   rsp_valid              out  product available
//   rsp_ready              in   consumer takes product
//   rsp_id                 out  requester owning the product
//   rsp_prod               out  unsigned A x B (7 bits)
//   grant_cnt0/grant_cnt1  out  accepted-request counts (stats build only)
// ---------------------------------------------------------------------------
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [A_W-1:0] req0_a,
  input  logic [B_W-1:0] req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [A_W-1:0] req1_a,
  input  logic [B_W-1:0] req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [P_W-1:0] rsp_prod
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  state_e         state_q, state_d;
  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  req_id_t        id_q, id_d;
  req_id_t        last_grant_q, last_grant_d;
  logic [P_W-1:0] prod_q, prod_d;
  logic [P_W-1:0] mul_prod;
  logic [1:0]     valid_vec;
  req_id_t        grant;
  logic           any_valid;
  logic           accept;

  assign valid_vec = {req1_valid, req0_valid};

  rr_arb2 u_rr_arb2 (
    .valid      (valid_vec),
    .last_grant (last_grant_q),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  // The grant only matters in IDLE; elsewhere no requester is accepted.
  assign accept = (state_q == IDLE) && any_valid;

  // Fed from the operand registers only, so the product depends solely on
  // what was latched at the accept edge.
  mul_arb_mult u_mult (
    .a_i    (a_q),
    .b_i    (b_q),
    .prod_o (mul_prod)
  );

  // ------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state elements use non-blocking assignment so every
      // register samples pre-edge values regardless of block order.
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_valid) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Readys depend only on state and the valids; rsp_ready never reaches them.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (accept) begin
      req0_ready = (grant == 1'b0);
      req1_ready = (grant == 1'b1);
    end
    rsp_valid = (state_q == RESP);
  end

  // ------------------------------------------------------------ datapath
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    prod_d       = prod_q;
    if (accept) begin
      a_d          = grant ? req1_a : req0_a;
      b_d          = grant ? req1_b : req0_b;
      id_d         = grant;
      last_grant_d = grant;
    end
    if (state_q == CALC) begin
      prod_d = mul_prod;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      prod_q       <= '0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      prod_q       <= prod_d;
    end
  end

  assign rsp_prod = prod_q;
  assign rsp_id   = id_q;

`ifdef MUL_ARB_STATS_EN
  // ------------------------------------------------------------ statistics
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (accept && (grant == 1'b0) && (cnt0_q != '1)) begin
      cnt0_d = cnt0_q + CNT_W'(1);
    end
    if (accept && (grant == 1'b1) && (cnt1_q != '1)) begin
      cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_arbiter
// Self-checking bench for mul_arbiter. A transaction-level reference model
// (busy flag, edges-until-response, last winner, pending product) predicts
// readys and the response channel; directed scenarios and a randomized run
// compare the DUT against it. Define MUL_ARB_STATS_EN to also exercise the
// grant counters with CNT_W = 2.
// ---------------------------------------------------------------------------
module tb_mul_arbiter;
  import mul_arb_pkg::*;

  localparam int TB_CNT_W = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [A_W-1:0] req0_a, req1_a;
  logic [B_W-1:0] req0_b, req1_b;
  logic           rsp_valid, rsp_ready, rsp_id;
  logic [P_W-1:0] rsp_prod;
`ifdef MUL_ARB_STATS_EN
  logic [TB_CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_arbiter #(.CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_prod   (rsp_prod)
`ifdef MUL_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // ------------------------------------------------------------ model
  bit m_busy;     // a transaction is in flight
  int m_wait;     // edges left before its product becomes visible
  bit m_last;     // winner of the most recent handshake
  bit m_id;
  int m_prod;
  int m_cnt0, m_cnt1;

  function automatic bit rr_pick(bit v0, bit v1, bit last);
    if (v0 && v1) return ~last;
    return v1 && !v0;
  endfunction

  function automatic bit exp_rsp_valid();
    return m_busy && (m_wait == 0);
  endfunction

  function automatic bit exp_ready(bit who);
    if (m_busy || !(req0_valid || req1_valid)) return 1'b0;
    return rr_pick(req0_valid, req1_valid, m_last) == who;
  endfunction

  function automatic int sat_inc(int v);
`ifdef MUL_ARB_STATS_EN
    return (v < (1 << TB_CNT_W) - 1) ? v + 1 : v;
`else
    return v + 1;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_wait = 0;
    m_last = 1'b1;
    m_id   = 1'b0;
    m_prod = 0;
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  task automatic drive_idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0;
    req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
  endtask

  // Advance one clock edge and apply the model's rules to the inputs seen
  // at that edge; returns 1 ns after the edge.
  task automatic tick();
    bit g;
    @(posedge clk);
    if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        g      = rr_pick(req0_valid, req1_valid, m_last);
        m_busy = 1'b1;
        m_wait = 1;
        m_last = g;
        m_id   = g;
        m_prod = g ? int'(req1_a) * int'(req1_b) : int'(req0_a) * int'(req0_b);
        if (g) m_cnt1 = sat_inc(m_cnt1);
        else   m_cnt0 = sat_inc(m_cnt0);
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (rsp_ready) begin
      m_busy = 1'b0;
    end
    #1;
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_prod !== 7'd0) begin errors++; $display("FAIL reset_rsp_prod: got %0d want 0", rsp_prod); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_readys: got %b want 00", {req1_ready, req0_ready}); end
`ifdef MUL_ARB_STATS_EN
    checks++; if ({grant_cnt1, grant_cnt0} !== '0) begin errors++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", grant_cnt0, grant_cnt1); end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single_req0();
    req0_valid = 1'b1; req0_a = 3'd5; req0_b = 4'd9;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready: got %b want 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_req1_ready: got %b want 0", req1_ready); end
    tick();
    req0_valid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_calc_valid: got %b want 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_prod !== 7'd45) begin errors++; $display("FAIL single_prod: got %0d want 45", rsp_prod); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b want 0", rsp_id); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_consumed: got %b want 0", rsp_valid); end
  endtask

  task automatic test_alternate();
    int exp_ids[4]   = '{0, 1, 0, 1};
    int exp_prods[4] = '{105, 12, 105, 12};
    int n = 0;
    test_reset();
    req0_valid = 1'b1; req0_a = 3'd7; req0_b = 4'd15;
    req1_valid = 1'b1; req1_a = 3'd3; req1_b = 4'd4;
    rsp_ready  = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      #1;
      checks++; if (rsp_valid !== exp_rsp_valid()) begin errors++; $display("FAIL alt_rsp_valid cyc %0d: got %b want %b", cyc, rsp_valid, exp_rsp_valid()); end
      if (rsp_valid === 1'b1 && n < 4) begin
        checks++; if (rsp_id !== 1'(exp_ids[n])) begin errors++; $display("FAIL alt_id #%0d: got %b want %0d", n, rsp_id, exp_ids[n]); end
        checks++; if (rsp_prod !== 7'(exp_prods[n])) begin errors++; $display("FAIL alt_prod #%0d: got %0d want %0d", n, rsp_prod, exp_prods[n]); end
        n++;
      end
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL alt_count: got %0d responses want 4", n); end
    drive_idle();
    // Drain whatever is still in flight.
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int guard = 0;
    req0_valid = 1'b1; req0_a = 3'd6; req0_b = 4'd11;
    req1_valid = 1'b1; req1_a = 3'd2; req1_b = 4'd13;
    rsp_ready  = 1'b0;
    while (rsp_valid !== 1'b1 && guard < 8) begin
      tick();
      guard++;
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_reach_resp: got %b want 1", rsp_valid); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d: got %b want 1", i, rsp_valid); end
      checks++; if (rsp_prod !== 7'(m_prod)) begin errors++; $display("FAIL bp_prod cyc %0d: got %0d want %0d", i, rsp_prod, m_prod); end
      checks++; if (rsp_id !== m_id) begin errors++; $display("FAIL bp_id cyc %0d: got %b want %b", i, rsp_id, m_id); end
      checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_readys cyc %0d: got %b want 00", i, {req1_ready, req0_ready}); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    checks++; if (req0_ready !== exp_ready(1'b0) || req1_ready !== exp_ready(1'b1)) begin
      errors++; $display("FAIL bp_after_consume readys: got %b want %b", {req1_ready, req0_ready}, {exp_ready(1'b1), exp_ready(1'b0)});
    end
    drive_idle();
    #1;
  endtask

  task automatic test_boundary();
    logic [A_W-1:0] ta[3] = '{3'd0, 3'd7, 3'd7};
    logic [B_W-1:0] tb[3] = '{4'd15, 4'd0, 4'd15};
    logic [P_W-1:0] tp[3] = '{7'd0, 7'd0, 7'd105};
    for (int k = 0; k < 3; k++) begin
      req1_valid = 1'b1; req1_a = ta[k]; req1_b = tb[k];
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bound_ready #%0d: got %b want 1", k, req1_ready); end
      tick();
      req1_valid = 1'b0;
      tick();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bound_valid #%0d: got %b want 1", k, rsp_valid); end
      checks++; if (rsp_prod !== tp[k]) begin errors++; $display("FAIL bound_prod #%0d: got %0d want %0d", k, rsp_prod, tp[k]); end
      checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL bound_id #%0d: got %b want 1", k, rsp_id); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_resp();
    req0_valid = 1'b1; req0_a = 3'd6; req0_b = 4'd13;
    tick();
    req0_valid = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", rsp_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_prod !== 7'd0) begin errors++; $display("FAIL midrst_prod: got %0d want 0", rsp_prod); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL midrst_id: got %b want 0", rsp_id); end
    model_reset();
    req1_valid = 1'b1; req1_a = 3'd1; req1_b = 4'd1;
    req0_valid = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL midrst_req0_first: got %b want 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL midrst_req1_wait: got %b want 0", req1_ready); end
    tick();
    drive_idle();
    req0_a = 3'd6; req0_b = 4'd13;
    tick();
    checks++; if (rsp_prod !== 7'd78 || rsp_id !== 1'b0) begin errors++; $display("FAIL midrst_rsp: got id %b prod %0d want id 0 prod 78", rsp_id, rsp_prod); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = 3'($urandom); req0_b = 4'($urandom);
      req1_a = 3'($urandom); req1_b = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (req0_ready !== exp_ready(1'b0)) begin errors++; $display("FAIL rnd_req0_ready cyc %0d: got %b want %b", c, req0_ready, exp_ready(1'b0)); end
      checks++; if (req1_ready !== exp_ready(1'b1)) begin errors++; $display("FAIL rnd_req1_ready cyc %0d: got %b want %b", c, req1_ready, exp_ready(1'b1)); end
      checks++; if (rsp_valid !== exp_rsp_valid()) begin errors++; $display("FAIL rnd_rsp_valid cyc %0d: got %b want %b", c, rsp_valid, exp_rsp_valid()); end
      if (exp_rsp_valid()) begin
        checks++; if (rsp_prod !== 7'(m_prod) || rsp_id !== m_id) begin
          errors++; $display("FAIL rnd_rsp cyc %0d: got id %b prod %0d want id %b prod %0d", c, rsp_id, rsp_prod, m_id, m_prod);
        end
      end
`ifdef MUL_ARB_STATS_EN
      checks++; if (int'(grant_cnt0) != m_cnt0 || int'(grant_cnt1) != m_cnt1) begin
        errors++; $display("FAIL rnd_cnts cyc %0d: got %0d/%0d want %0d/%0d", c, grant_cnt0, grant_cnt1, m_cnt0, m_cnt1);
      end
`endif
      tick();
    end
    drive_idle();
  endtask

`ifdef MUL_ARB_STATS_EN
  task automatic test_stats();
    int exp_cnt[5] = '{1, 2, 3, 3, 3};
    test_reset();
    for (int k = 0; k < 5; k++) begin
      req0_valid = 1'b1; req0_a = 3'd2; req0_b = 4'd3;
      tick();
      checks++; if (int'(grant_cnt0) != exp_cnt[k]) begin errors++; $display("FAIL stats_cnt0 #%0d: got %0d want %0d", k, grant_cnt0, exp_cnt[k]); end
      checks++; if (grant_cnt1 !== '0) begin errors++; $display("FAIL stats_cnt1 #%0d: got %0d want 0", k, grant_cnt1); end
      req0_valid = 1'b0;
      tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_req0();
    test_alternate();
    test_backpressure();
    test_boundary();
    test_reset_mid_resp();
    test_random();
`ifdef MUL_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
